// File: rtl/dec_nx_scan.sv
// N-to-2^N registered one-hot strobe decoder with an autonomous scan mode
// that steps the active output through 0..last, holding each index DWELL cycles.
module dec_nx_scan #(
  parameter int N       = 3,
  parameter int DWELL   = 4,
  parameter int ACT_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      code,
  input  logic              load,
  input  logic [N-1:0]      last,
  output logic [(1<<N)-1:0] dec,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 1 << N;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);
  localparam logic [W-1:0]  DEC_OFF   = (ACT_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  localparam logic [0:0] ST_DIRECT = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  logic [0:0]   state_reg, state_next;
  logic [N-1:0] idx_reg, idx_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic         wrap_reg, wrap_next;
  logic [W-1:0] dec_reg, dec_next;
  logic         on_next;
  logic [W-1:0] onehot_next;

  // One-hot of the index being registered, so dec and idx always agree.
  for (genvar gi = 0; gi < W; gi++) begin : g_onehot
    assign onehot_next[gi] = (idx_next == N'(gi));
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    dwell_next = dwell_reg;
    wrap_next  = 1'b0;
    on_next    = 1'b0;
    if (!mode) begin
      state_next = ST_DIRECT;
      idx_next   = code;
      dwell_next = '0;
      on_next    = en;
    end else if (en) begin
      on_next = 1'b1;
      if (state_reg == ST_DIRECT) begin
        state_next = ST_SCAN;
        idx_next   = '0;
        dwell_next = '0;
      end else if (load) begin
        idx_next   = code;
        dwell_next = '0;
      end else if (dwell_reg == DWELL_MAX) begin
        dwell_next = '0;
        // Explicit return to 0 also catches idx already beyond a lowered last.
        if (idx_reg < last) begin
          idx_next = idx_reg + N'(1);
        end else begin
          idx_next  = '0;
          wrap_next = 1'b1;
        end
      end else begin
        dwell_next = dwell_reg + DW'(1);
      end
    end
    if (!on_next) begin
      dec_next = DEC_OFF;
    end else if (ACT_LOW != 0) begin
      dec_next = ~onehot_next;
    end else begin
      dec_next = onehot_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_DIRECT;
      idx_reg   <= '0;
      dwell_reg <= '0;
      wrap_reg  <= 1'b0;
      dec_reg   <= DEC_OFF;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      dwell_reg <= dwell_next;
      wrap_reg  <= wrap_next;
      dec_reg   <= dec_next;
    end
  end

  assign dec  = dec_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_dec_nx_scan.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares
// against three instances (DWELL=4 active-high, DWELL=4 active-low, DWELL=1).
module tb_dec_nx_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [2:0] code, last;
  logic [7:0] dec0, dec1, dec2;
  logic [2:0] idx0, idx1, idx2;
  logic       wrap0, wrap1, wrap2;

  always #5 clk = ~clk;

  dec_nx_scan #(.N(3), .DWELL(4), .ACT_LOW(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code), .load(load),
    .last(last), .dec(dec0), .idx(idx0), .wrap(wrap0));
  dec_nx_scan #(.N(3), .DWELL(4), .ACT_LOW(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code), .load(load),
    .last(last), .dec(dec1), .idx(idx1), .wrap(wrap1));
  dec_nx_scan #(.N(3), .DWELL(1), .ACT_LOW(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code), .load(load),
    .last(last), .dec(dec2), .idx(idx2), .wrap(wrap2));

  typedef struct {
    logic [7:0] dec4;
    logic [2:0] idx4;
    logic       wrap4;
    logic [7:0] dec1;
    logic [2:0] idx1;
    logic       wrap1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: k=0 for DWELL=4, k=1 for DWELL=1.
  int   m_idx[2];
  int   m_held[2];
  bit   m_scan[2];
  bit   m_on[2];
  bit   m_wrap[2];

  task automatic model_step(input int k, input int dw);
    m_wrap[k] = 1'b0;
    if (rst) begin
      m_idx[k] = 0; m_held[k] = 0; m_scan[k] = 0; m_on[k] = 0;
    end else if (!mode) begin
      m_idx[k] = int'(code); m_held[k] = 0; m_scan[k] = 0; m_on[k] = en;
    end else if (!en) begin
      m_on[k] = 0;
    end else begin
      m_on[k] = 1;
      if (!m_scan[k]) begin
        m_scan[k] = 1; m_idx[k] = 0; m_held[k] = 0;
      end else if (load) begin
        m_idx[k] = int'(code); m_held[k] = 0;
      end else begin
        m_held[k] = m_held[k] + 1;
        if (m_held[k] == dw) begin
          m_held[k] = 0;
          if (m_idx[k] < int'(last)) m_idx[k] = m_idx[k] + 1;
          else begin
            m_idx[k] = 0; m_wrap[k] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] strobe(input int k);
    return m_on[k] ? (8'd1 << m_idx[k]) : 8'd0;
  endfunction

  task automatic step(input logic r, input logic e, input logic m,
                      input logic [2:0] c, input logic l, input logic [2:0] la);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; code = c; load = l; last = la;
    model_step(0, 4);
    model_step(1, 1);
    x.dec4 = strobe(0); x.idx4 = 3'(m_idx[0]); x.wrap4 = m_wrap[0];
    x.dec1 = strobe(1); x.idx1 = 3'(m_idx[1]); x.wrap1 = m_wrap[1];
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [7:0] ad, input logic [2:0] ai,
                       input logic aw, input logic [7:0] ed, input logic [2:0] ei,
                       input logic ew);
    n_cmp++;
    if (ad !== ed || ai !== ei || aw !== ew) begin
      n_bad++;
      $display("FAIL %s t=%0t: got dec=%h idx=%0d wrap=%b, want dec=%h idx=%0d wrap=%b",
               name, $time, ad, ai, aw, ed, ei, ew);
    end else begin
      $display("ok %s t=%0t: dec=%h idx=%0d wrap=%b", name, $time, ad, ai, aw);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("dwell4_hi", dec0, idx0, wrap0, x.dec4, x.idx4, x.wrap4);
      check("dwell4_lo", dec1, idx1, wrap1, ~x.dec4, x.idx4, x.wrap4);
      check("dwell1_hi", dec2, idx2, wrap2, x.dec1, x.idx1, x.wrap1);
    end
  end

  initial begin
    logic       r_mode;
    logic [2:0] r_last;
    rst = 1'b1; en = 1'b1; mode = 1'b1; code = '0; load = 1'b0; last = 3'd7;

    // Reset with scan requested, then first scan cycle.
    repeat (2) step(1, 1, 1, 0, 0, 7);
    repeat (3) step(0, 1, 1, 0, 0, 7);

    // Direct decode sweep, then disable.
    for (int c = 0; c < 8; c++) step(0, 1, 0, 3'(c), 0, 7);
    step(0, 0, 0, 3'd5, 0, 7);
    step(0, 0, 0, 3'd5, 1, 7);

    // Scan 0..5 with wrap, several periods.
    repeat (60) step(0, 1, 1, 0, 0, 5);

    // Load beats dwell expiry at idx=2, dwell=3.
    step(0, 1, 0, 0, 0, 7);
    for (int i = 0; i < 100 && !(m_idx[0] == 2 && m_held[0] == 3); i++)
      step(0, 1, 1, 0, 0, 7);
    step(0, 1, 1, 3'd6, 1, 7);
    repeat (14) step(0, 1, 1, 0, 0, 7);

    // Lower last below the current index.
    step(0, 1, 1, 3'd6, 1, 7);
    step(0, 1, 1, 0, 0, 7);
    repeat (8) step(0, 1, 1, 0, 0, 3);

    // last = 0: idx pinned at 0, wrap every DWELL cycles.
    repeat (16) step(0, 1, 1, 0, 0, 0);

    // Freeze mid-dwell at idx=4 then resume.
    step(0, 1, 1, 3'd4, 1, 7);
    repeat (2) step(0, 1, 1, 0, 0, 7);
    repeat (10) step(0, 0, 1, 3'd1, 1, 7);
    repeat (8) step(0, 1, 1, 0, 0, 7);

    // Randomized traffic.
    r_mode = 1'b1;
    r_last = 3'd7;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 29) == 0) r_last = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), r_mode,
           3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0), r_last);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dec_nx_scan.md
Name: dec_nx_scan

Overview:
- Parametrised successor to the team's 3-to-8 enable decoder: N-bit code to 2^N one-hot output, registered.
- Adds an autonomous scan mode that steps the active output through indices 0..last with a programmable dwell, for digit/row strobing on the lab display and keypad boards.
- Sits between control logic (code/mode source) and the strobe pins; `dec` drives select lines directly.

Parameters:
- N, 3, code width; output width is 2^N (N >= 1).
- DWELL, 4, clock cycles each index is held in scan mode (DWELL >= 1).
- ACT_LOW, 0, 1 = dec outputs inverted (active-low strobes); applies to `dec` only.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low forces all strobes inactive and freezes scan state.
- mode  input  1  0 = direct decode, 1 = scan.
- code  input  N  direct-mode index / scan-mode load value.
- load  input  1  scan mode: load `code` into the index counter.
- last  input  N  scan mode: highest index visited before wrap.
- dec  output  2^N  one-hot strobe (inverted if ACT_LOW).
- idx  output  N  index currently driven on `dec`.
- wrap  output  1  one-cycle pulse when the scan returns from `last` to 0.

Behaviour:
- Reset (rst=1 at edge): idx=0, dwell counter=0, wrap=0, dec all inactive (all 0, or all 1 if ACT_LOW). rst wins over every other input.
- Inactive value: dec bits are 0 (ACT_LOW=0) or 1 (ACT_LOW=1).
- Direct mode (mode=0):
  - Each edge: idx<=code; dec<=onehot(code) if en, else all inactive.
  - Latency 1 cycle. wrap=0. Dwell counter held at 0.
- Scan mode (mode=1):
  - The dwell counter counts 0..DWELL-1. At DWELL-1 it returns to 0 and idx advances.
  - Advance: idx<=idx+1 if idx<last, else idx<=0 with wrap=1 for that one cycle.
  - dec = onehot(idx), registered together with idx, so dec always matches idx.
- Mode entry: first cycle with mode=1 after mode=0, or after reset: idx<=0, dwell<=0, no wrap.
- load=1 in scan mode: idx<=code, dwell<=0, no wrap.
  - load beats a dwell expiry in the same cycle.
  - load is ignored in direct mode.
- Out-of-range index: if idx>last (after a load, or after `last` is lowered), the next advance goes to 0 and asserts wrap.
- last=0: idx stays 0; wrap pulses once every DWELL cycles.
- DWELL=1: idx advances every cycle.
- en=0 in scan mode:
  - dec all inactive; idx and dwell hold; wrap=0; load ignored.
  - Scan resumes from the held state when en returns.
- Widths: dwell counter is clog2(DWELL) bits (minimum 1). idx arithmetic is N-bit with no carry out. The last-to-0 step is explicit, not modulo 2^N.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: hold rst 2 cycles with mode=1, en=1. Expect dec=8'h00, idx=0, wrap=0. Release; in the first scan cycle expect dec=8'h01.
- Direct decode, N=3: en=1, mode=0, sweep code 0..7. Expect dec=8'h01,02,04,...,80 one cycle later, each time. Then en=0: expect dec=8'h00 on the next cycle.
- Scan, N=3, DWELL=4, last=5: expect idx to go 0,1,2,3,4,5,0 with each value held 4 cycles. Expect wrap high for exactly 1 cycle, coincident with idx returning to 0. Expect 24 cycles between wrap pulses.
- Load vs. dwell expiry: during scan at idx=2, dwell=3, assert load with code=6, last=7. Expect idx=6 and dwell restarted, so idx=6 is held a full 4 cycles. Then expect 7, then 0 with wrap.
- Boundaries:
  - Lower last from 7 to 3 while idx=6: expect the next advance to go to 0 with wrap=1.
  - last=0: expect dec=8'h01 held, with wrap every 4 cycles.
- en freeze and ACT_LOW=1: drop en mid-dwell at idx=4. Expect dec=8'hFF and idx=4 held for 10 cycles. Restore en; expect dec=8'hEF, and the remaining dwell cycles of idx=4 complete before idx=5.
